// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and default timing for the PC sequencer
package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_RUN        = 3'd0,
        S_REDIRECT_J = 3'd1,
        S_WAIT_COND  = 3'd2,
        S_REDIRECT_B = 3'd3,
        S_HALT       = 3'd4,
        S_FAULT      = 3'd5
    } state_e;

    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned TW_DEF      = 4;

endpackage

// File: rtl/resolve_timer.sv
// resolve_timer: saturating counter that flags when a branch resolve has waited too long
module resolve_timer #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TW      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TW-1:0] cnt_q, cnt_d;

    // next count: clear wins, otherwise count up while enabled and saturate at all-ones
    always_comb begin
        cnt_d   = clear ? '0 : (enable && cnt_q != '1) ? cnt_q + TW'(1) : cnt_q;
        expired = cnt_d == TW'(TIMEOUT);
    end

    // count register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: decides each cycle whether the PC holds, increments, jumps or branches
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned TW      = TW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dec_valid,
    input  logic          dec_jump,
    input  logic          dec_branch,
    input  logic          dec_halt,
    input  logic [AW-1:0] jump_tgt,
    input  logic [AW-1:0] branch_tgt,
    input  logic          cond_valid,
    input  logic          cond_taken,
    input  logic          mem_stall,
    input  logic          resume,
    output logic          sel_j,
    output logic          sel_b,
    output logic [AW-1:0] jump_addr,
    output logic [AW-1:0] branch_addr,
    output logic          pc_hold,
    output logic          flush,
    output logic          fault,
    output logic [2:0]    state_o
);

    state_e        state_q, state_d;
    logic [AW-1:0] jump_q, jump_d, branch_q, branch_d;
    logic          fault_q, fault_d;
    logic          tmr_clear, tmr_enable, tmr_expired;

    // counts WAIT_COND cycles; expired marks the cycle in which the count reaches TIMEOUT
    resolve_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    // next state, target capture and PC control; decode is only looked at in RUN
    always_comb begin
        state_d    = state_q;
        jump_d     = jump_q;
        branch_d   = branch_q;
        fault_d    = fault_q;
        sel_j      = 1'b0;
        sel_b      = 1'b0;
        pc_hold    = 1'b0;
        flush      = 1'b0;
        tmr_clear  = 1'b0;
        tmr_enable = 1'b0;
        case (state_q)
            S_RUN: begin
                if (dec_valid && dec_halt) begin
                    pc_hold = 1'b1;
                    state_d = S_HALT;
                end else if (dec_valid && dec_jump) begin
                    pc_hold = 1'b1;
                    flush   = 1'b1;
                    jump_d  = jump_tgt;
                    state_d = S_REDIRECT_J;
                end else if (dec_valid && dec_branch) begin
                    pc_hold   = 1'b1;
                    branch_d  = branch_tgt;
                    tmr_clear = 1'b1;
                    state_d   = S_WAIT_COND;
                end else begin
                    pc_hold = mem_stall;
                end
            end
            S_REDIRECT_J: begin
                pc_hold = mem_stall;
                sel_j   = ~mem_stall;
                flush   = ~mem_stall;
                state_d = mem_stall ? S_REDIRECT_J : S_RUN;
            end
            S_WAIT_COND: begin
                tmr_enable = 1'b1;
                pc_hold    = 1'b1;
                // a condition arriving in the last allowed cycle beats the timeout
                if (cond_valid && cond_taken) begin
                    flush   = 1'b1;
                    state_d = S_REDIRECT_B;
                end else if (cond_valid) begin
                    pc_hold = mem_stall;
                    state_d = S_RUN;
                end else if (tmr_expired) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end
            end
            S_REDIRECT_B: begin
                pc_hold = mem_stall;
                sel_b   = ~mem_stall;
                flush   = ~mem_stall;
                state_d = mem_stall ? S_REDIRECT_B : S_RUN;
            end
            S_HALT: begin
                pc_hold = 1'b1;
                state_d = resume ? S_RUN : S_HALT;
            end
            S_FAULT: begin
                pc_hold = 1'b1;
            end
            default: begin
                pc_hold = 1'b1;
                state_d = S_RUN;
            end
        endcase
    end

    // state, captured targets and sticky fault
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_RUN;
            jump_q   <= '0;
            branch_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            jump_q   <= jump_d;
            branch_q <= branch_d;
            fault_q  <= fault_d;
        end
    end

    assign jump_addr   = jump_q;
    assign branch_addr = branch_q;
    assign fault       = fault_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer with a simple PC model
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid, dec_jump, dec_branch, dec_halt;
    logic [31:0] jump_tgt, branch_tgt;
    logic        cond_valid, cond_taken, mem_stall, resume;
    logic        sel_j, sel_b, pc_hold, flush, fault;
    logic [31:0] jump_addr, branch_addr;
    logic [2:0]  state_o;
    logic [31:0] pc;
    int          checks = 0;
    int          errors = 0;

    pc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .dec_valid   (dec_valid),
        .dec_jump    (dec_jump),
        .dec_branch  (dec_branch),
        .dec_halt    (dec_halt),
        .jump_tgt    (jump_tgt),
        .branch_tgt  (branch_tgt),
        .cond_valid  (cond_valid),
        .cond_taken  (cond_taken),
        .mem_stall   (mem_stall),
        .resume      (resume),
        .sel_j       (sel_j),
        .sel_b       (sel_b),
        .jump_addr   (jump_addr),
        .branch_addr (branch_addr),
        .pc_hold     (pc_hold),
        .flush       (flush),
        .fault       (fault),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // PC register as the sequencer would drive it
    always @(posedge clk) begin
        if (reset)         pc <= 32'h0;
        else if (!pc_hold) pc <= sel_j ? jump_addr : sel_b ? branch_addr : pc + 32'd4;
    end

    // select invariants hold in every cycle
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (!(sel_j && sel_b) && !(pc_hold && (sel_j || sel_b))) else begin
                errors++;
                $error("FAIL sel_invariant: sel_j=%0b sel_b=%0b pc_hold=%0b required no double select and no select under hold", sel_j, sel_b, pc_hold);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clr_dec();
        dec_valid = 0; dec_jump = 0; dec_branch = 0; dec_halt = 0;
    endtask

    initial begin
        reset = 1; clr_dec(); jump_tgt = 0; branch_tgt = 0;
        cond_valid = 0; cond_taken = 0; mem_stall = 0; resume = 0;
        tick(); tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_jaddr", jump_addr, 32'h0);
        chk("rst_baddr", branch_addr, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_outs", {28'd0, sel_j, sel_b, pc_hold, flush}, 32'd0);
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("run_outs", {29'd0, sel_j, sel_b, pc_hold}, 32'd0);
            chk("run_state", 32'(state_o), 32'd0);
            tick();
        end
        chk("run_pc", pc, 32'd20);

        dec_valid = 1; dec_jump = 1; jump_tgt = 32'h40;
        #1;
        chk("jmp_dec", {29'd0, sel_j, pc_hold, flush}, 32'b011);
        tick();
        clr_dec();
        #1;
        chk("jmp_state", 32'(state_o), 32'd1);
        chk("jmp_redir", {29'd0, sel_j, pc_hold, flush}, 32'b101);
        chk("jmp_addr", jump_addr, 32'h40);
        tick();
        chk("jmp_pc", pc, 32'h40);
        chk("jmp_back", 32'(state_o), 32'd0);

        dec_valid = 1; dec_branch = 1; branch_tgt = 32'h80;
        #1;
        chk("br_dec_hold", 32'(pc_hold), 32'd1);
        tick();
        clr_dec();
        #1;
        chk("br_w1", {29'd0, state_o}, 32'd2);
        chk("br_w1_hold", 32'(pc_hold), 32'd1);
        chk("br_addr", branch_addr, 32'h80);
        tick();
        #1;
        chk("br_w2_hold", 32'(pc_hold), 32'd1);
        tick();
        cond_valid = 1; cond_taken = 1;
        #1;
        chk("br_taken_cyc", {30'd0, pc_hold, flush}, 32'b11);
        tick();
        cond_valid = 0; cond_taken = 0;
        #1;
        chk("br_redir_state", 32'(state_o), 32'd3);
        chk("br_redir", {29'd0, sel_b, pc_hold, flush}, 32'b101);
        tick();
        chk("br_pc", pc, 32'h80);

        dec_valid = 1; dec_branch = 1; branch_tgt = 32'h100;
        tick();
        clr_dec();
        tick(); tick();
        cond_valid = 1; cond_taken = 0;
        #1;
        chk("nt_cyc", {29'd0, sel_b, pc_hold, flush}, 32'b000);
        tick();
        cond_valid = 0;
        chk("nt_state", 32'(state_o), 32'd0);
        chk("nt_pc", pc, 32'h84);

        dec_valid = 1; dec_jump = 1; jump_tgt = 32'h200;
        tick();
        clr_dec();
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_state", 32'(state_o), 32'd1);
            chk("stall_sel", {30'd0, sel_j, pc_hold}, 32'b01);
            tick();
        end
        mem_stall = 0;
        #1;
        chk("stall_release", {30'd0, sel_j, flush}, 32'b11);
        tick();
        #1;
        chk("stall_after", 32'(sel_j), 32'd0);
        chk("stall_pc", pc, 32'h200);

        dec_valid = 1; dec_halt = 1; dec_jump = 1; jump_tgt = 32'h300;
        #1;
        chk("halt_dec", {30'd0, pc_hold, flush}, 32'b10);
        tick();
        #1;
        chk("halt_state", 32'(state_o), 32'd4);
        chk("halt_jaddr", jump_addr, 32'h200);
        chk("halt_ignore", {30'd0, sel_j, pc_hold}, 32'b01);
        tick();
        clr_dec();
        chk("halt_stay", 32'(state_o), 32'd4);
        resume = 1;
        #1;
        chk("resume_hold", 32'(pc_hold), 32'd1);
        tick();
        resume = 0;
        #1;
        chk("resume_state", 32'(state_o), 32'd0);
        chk("resume_pc", pc, 32'h200);
        tick();
        chk("resume_inc", pc, 32'h204);

        dec_valid = 1; dec_branch = 1; branch_tgt = 32'h400;
        tick();
        clr_dec();
        tick();
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("rst_wait_state", 32'(state_o), 32'd0);
        chk("rst_wait_baddr", branch_addr, 32'h0);
        chk("rst_wait_hold", 32'(pc_hold), 32'd0);

        dec_valid = 1; dec_branch = 1; branch_tgt = 32'hC0;
        tick();
        clr_dec();
        for (int i = 0; i < 15; i++) begin
            #1;
            chk("to_wait", {28'd0, fault, state_o}, 32'd2);
            tick();
        end
        #1;
        chk("to_state", 32'(state_o), 32'd5);
        chk("to_fault", 32'(fault), 32'd1);
        cond_valid = 1; cond_taken = 1; resume = 1; dec_valid = 1; dec_jump = 1;
        #1;
        chk("fault_ignore", {29'd0, sel_j, sel_b, pc_hold}, 32'b001);
        tick();
        cond_valid = 0; cond_taken = 0; resume = 0; clr_dec();
        chk("fault_stay", {28'd0, fault, state_o}, 32'hD);
        reset = 1;
        tick();
        reset = 0;
        chk("fault_rst", {28'd0, fault, state_o}, 32'd0);

        dec_valid = 1; dec_branch = 1; branch_tgt = 32'hE0;
        tick();
        clr_dec();
        for (int i = 0; i < 14; i++) tick();
        cond_valid = 1; cond_taken = 1;
        tick();
        cond_valid = 0; cond_taken = 0;
        chk("last_cyc_cond", {28'd0, fault, state_o}, 32'd3);
        tick();
        chk("last_cyc_pc", pc, 32'hE0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
